// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: owns the PC, issues single-word reads to the
// instruction RAM and hands the returned word to the IR via a load strobe.
module fetch_ctrl #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              fetch_req,
    input  logic              pc_ld,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              err_clr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ir_ld,
    output logic [DATA_W-1:0] ir_data,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done,
    output logic              fetch_err
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        LOAD = 2'd2,
        ERR  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // State and datapath registers; reset aborts any transfer in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= ADDR_W'(RESET_PC);
            buf_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; an ack on the last permitted READ cycle beats the timeout.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pc_ld) begin
                    pc_d = pc_in;
                end else if (fetch_req) begin
                    state_d = READ;
                    cnt_d   = '0;
                end
            end
            READ: begin
                if (mem_ack) begin
                    buf_d   = mem_rdata;
                    state_d = LOAD;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LOAD: begin
                pc_d    = pc_q + ADDR_W'(1);
                state_d = IDLE;
            end
            ERR: begin
                if (err_clr) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode straight from the state register so reset drops them at once.
    assign mem_rd    = (state_q == READ);
    assign ir_ld     = (state_q == LOAD);
    assign done      = (state_q == LOAD);
    assign busy      = (state_q == READ) || (state_q == LOAD);
    assign fetch_err = (state_q == ERR);
    assign mem_addr  = pc_q;
    assign pc        = pc_q;
    assign ir_data   = buf_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: zero-wait and wait-state fetches, PC load and
// wrap, timeout/error recovery, last-cycle ack and asynchronous reset abort.
module tb_fetch_ctrl;

    logic        clock;
    logic        reset_n;
    logic        fetch_req;
    logic        pc_ld;
    logic [15:0] pc_in;
    logic        err_clr;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        ir_ld;
    logic [15:0] ir_data;
    logic [15:0] pc;
    logic        busy;
    logic        done;
    logic        fetch_err;

    int passed = 0;
    int total  = 0;

    fetch_ctrl #(
        .ADDR_W  (16),
        .DATA_W  (16),
        .RESET_PC(0),
        .TIMEOUT (16)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .fetch_req(fetch_req),
        .pc_ld    (pc_ld),
        .pc_in    (pc_in),
        .err_clr  (err_clr),
        .mem_rd   (mem_rd),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .ir_ld    (ir_ld),
        .ir_data  (ir_data),
        .pc       (pc),
        .busy     (busy),
        .done     (done),
        .fetch_err(fetch_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        reset_n   = 1'b0;
        fetch_req = 1'b0;
        pc_ld     = 1'b0;
        pc_in     = 16'h0000;
        err_clr   = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
        step();
        step();
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_ir_ld", 32'(ir_ld), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(fetch_err), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'h0000);
        check("rst_ir_data", 32'(ir_data), 32'h0000);
        check("rst_pc", 32'(pc), 32'h0000);
        reset_n = 1'b1;
        step();

        // Ack in IDLE must be ignored
        mem_ack   = 1'b1;
        mem_rdata = 16'h5555;
        step();
        check("idle_ack_busy", 32'(busy), 32'd0);
        check("idle_ack_ir_ld", 32'(ir_ld), 32'd0);

        // Zero-wait fetch of 0xA5A5 from address 0
        fetch_req = 1'b1;
        mem_rdata = 16'hA5A5;
        step();
        fetch_req = 1'b0;
        check("zw_mem_rd", 32'(mem_rd), 32'd1);
        check("zw_addr", 32'(mem_addr), 32'h0000);
        check("zw_busy", 32'(busy), 32'd1);
        check("zw_ir_ld_early", 32'(ir_ld), 32'd0);
        step();
        mem_ack = 1'b0;
        check("zw_ir_ld", 32'(ir_ld), 32'd1);
        check("zw_done", 32'(done), 32'd1);
        check("zw_ir_data", 32'(ir_data), 32'h0000A5A5);
        check("zw_mem_rd_off", 32'(mem_rd), 32'd0);
        check("zw_pc_before", 32'(pc), 32'h0000);
        step();
        check("zw_ir_ld_drop", 32'(ir_ld), 32'd0);
        check("zw_done_drop", 32'(done), 32'd0);
        check("zw_pc_after", 32'(pc), 32'h0001);
        check("zw_ir_hold", 32'(ir_data), 32'h0000A5A5);
        check("zw_busy_off", 32'(busy), 32'd0);

        // Three wait states: READ lasts four cycles at address 1
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("ws_mem_rd", 32'(mem_rd), 32'd1);
            check("ws_addr", 32'(mem_addr), 32'h0001);
            check("ws_busy", 32'(busy), 32'd1);
            check("ws_no_ir_ld", 32'(ir_ld), 32'd0);
            if (i == 3) begin
                mem_ack   = 1'b1;
                mem_rdata = 16'h1234;
            end
            step();
        end
        mem_ack = 1'b0;
        check("ws_ir_ld", 32'(ir_ld), 32'd1);
        check("ws_busy_load", 32'(busy), 32'd1);
        check("ws_mem_rd_off", 32'(mem_rd), 32'd0);
        check("ws_ir_data", 32'(ir_data), 32'h00001234);
        step();
        check("ws_pc_after", 32'(pc), 32'h0002);

        // PC load wins over a simultaneous fetch, then fetch at 0xFFFF wraps
        pc_ld     = 1'b1;
        pc_in     = 16'hFFFF;
        fetch_req = 1'b1;
        step();
        pc_ld = 1'b0;
        check("pl_no_fetch", 32'(mem_rd), 32'd0);
        check("pl_busy", 32'(busy), 32'd0);
        check("pl_pc", 32'(pc), 32'h0000FFFF);
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
        step();
        fetch_req = 1'b0;
        check("pl_mem_rd", 32'(mem_rd), 32'd1);
        check("pl_addr", 32'(mem_addr), 32'h0000FFFF);
        step();
        mem_ack = 1'b0;
        check("pl_ir_data", 32'(ir_data), 32'h0000BEEF);
        check("pl_ir_ld", 32'(ir_ld), 32'd1);
        step();
        check("pl_wrap", 32'(pc), 32'h0000);

        // No ack: READ for exactly 16 cycles, then ERR
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("to_mem_rd", 32'(mem_rd), 32'd1);
            check("to_no_err", 32'(fetch_err), 32'd0);
            step();
        end
        check("to_err", 32'(fetch_err), 32'd1);
        check("to_mem_rd_off", 32'(mem_rd), 32'd0);
        check("to_busy_off", 32'(busy), 32'd0);
        fetch_req = 1'b1;
        pc_ld     = 1'b1;
        pc_in     = 16'h1234;
        step();
        check("err_ignore_req", 32'(mem_rd), 32'd0);
        check("err_hold", 32'(fetch_err), 32'd1);
        check("err_pc_hold", 32'(pc), 32'h0000);
        fetch_req = 1'b0;
        pc_ld     = 1'b0;
        err_clr   = 1'b1;
        step();
        err_clr = 1'b0;
        check("clr_err", 32'(fetch_err), 32'd0);
        check("clr_pc", 32'(pc), 32'h0000);
        check("clr_busy", 32'(busy), 32'd0);

        // Ack on the 16th READ cycle wins over the timeout
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("late_mem_rd", 32'(mem_rd), 32'd1);
            if (i == 15) begin
                mem_ack   = 1'b1;
                mem_rdata = 16'hC3C3;
            end
            step();
        end
        mem_ack = 1'b0;
        check("late_no_err", 32'(fetch_err), 32'd0);
        check("late_ir_ld", 32'(ir_ld), 32'd1);
        check("late_ir_data", 32'(ir_data), 32'h0000C3C3);
        step();
        check("late_pc", 32'(pc), 32'h0001);
        check("late_err_off", 32'(fetch_err), 32'd0);

        // Asynchronous reset between edges while in READ
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        step();
        check("ar_pre_mem_rd", 32'(mem_rd), 32'd1);
        check("ar_pre_addr", 32'(mem_addr), 32'h0001);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_mem_rd", 32'(mem_rd), 32'd0);
        check("ar_ir_ld", 32'(ir_ld), 32'd0);
        check("ar_pc", 32'(pc), 32'h0000);
        check("ar_addr", 32'(mem_addr), 32'h0000);
        mem_ack   = 1'b1;
        mem_rdata = 16'h7777;
        step();
        check("ar_hold_ir_ld", 32'(ir_ld), 32'd0);
        reset_n = 1'b1;
        step();
        mem_ack = 1'b0;
        check("ar_post_ir_ld", 32'(ir_ld), 32'd0);
        check("ar_post_busy", 32'(busy), 32'd0);
        check("ar_post_ir_data", 32'(ir_data), 32'h0000);
        check("ar_post_pc", 32'(pc), 32'h0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction fetch controller: owns the program counter, issues single-word read requests to the instruction RAM, waits on the RAM acknowledge, and drives the instruction register's load strobe and data input. It sits between the control unit (which requests fetches and redirects the PC) and the RAM read port. It is the producer end of the IR load interface: the IR captures `ir_data` on the clock edge that ends any cycle in which `ir_ld` is high.

## Interface
- `ADDR_W`, 16, PC and RAM address width.
- `DATA_W`, 16, instruction width.
- `RESET_PC`, 0, PC value after reset.
- `TIMEOUT`, 16, maximum cycles spent in READ without `mem_ack` before an error; legal range 2..256.

- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `fetch_req`  in  1  level request from the control unit; sampled only in IDLE.
- `pc_ld`  in  1  load `pc_in` into the PC; sampled only in IDLE.
- `pc_in`  in  ADDR_W  branch/jump target.
- `err_clr`  in  1  clears the error; sampled only in ERR.
- `mem_rd`  out  1  read request to RAM.
- `mem_addr`  out  ADDR_W  read address.
- `mem_ack`  in  1  RAM data valid; `mem_rdata` is sampled on the edge that ends the cycle in which `mem_ack` is high.
- `mem_rdata`  in  DATA_W  RAM read data.
- `ir_ld`  out  1  IR load strobe.
- `ir_data`  out  DATA_W  instruction to the IR.
- `pc`  out  ADDR_W  current PC.
- `busy`  out  1  high in READ and LOAD.
- `done`  out  1  one-cycle pulse, coincident with `ir_ld`.
- `fetch_err`  out  1  high while in ERR.

## Operation
- States: IDLE, READ, LOAD, ERR. All outputs are registered or decoded from the state.
- Reset (while `reset_n`=0):
  - state = IDLE
  - `pc` = RESET_PC
  - instruction buffer = 0
  - wait counter = 0
  - `mem_rd`, `ir_ld`, `busy`, `done`, `fetch_err` = 0
  - `mem_addr` = RESET_PC
  - `ir_data` = 0
- IDLE:
  - If `pc_ld`=1: `pc` <= `pc_in`. `fetch_req` is ignored that cycle (a load has priority over a fetch).
  - Else if `fetch_req`=1: go to READ and clear the wait counter.
- READ:
  - `mem_rd`=1, `mem_addr`=`pc`, and both are held stable until exit.
  - If `mem_ack`=1: buffer <= `mem_rdata`, then go to LOAD.
  - Else if the wait counter equals TIMEOUT-1: go to ERR.
  - Else the counter increments.
  - `mem_ack` outside READ is ignored.
- LOAD:
  - `ir_ld`=1, `done`=1, `ir_data`=buffer.
  - `pc` <= `pc`+1 modulo 2^ADDR_W, so 0xFFFF wraps to 0x0000.
  - Next state is IDLE.
- ERR:
  - `fetch_err`=1; the PC is unchanged.
  - Stays in ERR until `err_clr`=1, then goes to IDLE.
  - `fetch_req` and `pc_ld` are ignored in ERR.
- `ir_data` holds the last loaded instruction outside LOAD. The IR must still update only on `ir_ld`.
- Asserting `reset_n` low in any state aborts immediately:
  - `mem_rd` and `ir_ld` drop asynchronously.
  - No IR load occurs.
  - The PC returns to RESET_PC.

## Timing
- `fetch_req` is sampled at edge E0 in IDLE, so `mem_rd` rises after E0.
- If `mem_ack` is high in the first READ cycle, the data is captured at E1, `ir_ld` is high in the cycle after E1, and the IR updates and PC increments at E2.
- Minimum request-to-IR-update latency is 2 edges. Each cycle of `mem_ack` delay adds one edge.
- The earliest next fetch is sampled at E3 (IDLE). Back-to-back throughput is 1 instruction per 3 cycles with a zero-wait RAM.
- Timeout: with `mem_ack` never asserted, `mem_rd` is high for exactly TIMEOUT cycles, then `fetch_err` rises.
- `mem_ack` in the same cycle the counter reaches TIMEOUT-1 wins: data is captured and there is no error.
- A `pc_ld` in IDLE takes effect at the next edge. A fetch requested in the following cycle reads `pc_in`.

## Test plan
- Reset, zero-wait RAM returning 0xA5A5, `fetch_req` pulse:
  - `mem_addr`=0x0000.
  - `ir_ld`/`done` high for exactly 1 cycle with `ir_data`=0xA5A5.
  - `pc`=0x0001 afterwards.
- RAM acks after 3 wait cycles:
  - `mem_rd` high for 4 cycles with `mem_addr` stable.
  - `ir_ld` follows one cycle after the ack cycle.
  - `busy` is high throughout.
- `pc_ld`=1 with `pc_in`=0xFFFF and `fetch_req`=1 in the same IDLE cycle:
  - No fetch starts and `pc`=0xFFFF.
  - A subsequent fetch reads 0xFFFF, then `pc` wraps to 0x0000.
- No ack with TIMEOUT=16:
  - `mem_rd` is high for 16 cycles, then `fetch_err`=1 and `mem_rd`=0.
  - `fetch_req` in ERR is ignored.
  - `err_clr` returns to IDLE with `pc` unchanged.
- Ack arriving on the 16th READ cycle: the fetch completes normally and `fetch_err` stays 0.
- `reset_n` pulled low mid-READ (asynchronously, between edges): `mem_rd`=0 immediately, no `ir_ld` pulse, and `pc`=RESET_PC.
